// File: rtl/set_assoc_lru_cache.sv
// N-way set-associative write-back / write-allocate cache with true-LRU replacement.
// One word per line; the miss sequence (victim write-back, refill, response) runs through valid/ready handshakes.
module set_assoc_lru_cache #(
  parameter int unsigned NUM_SETS    = 4,
  parameter int unsigned NUM_WAYS    = 4,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned VALUE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [VALUE_WIDTH-1:0] req_wdata,
  output logic                   resp_valid,
  output logic [VALUE_WIDTH-1:0] resp_rdata,
  output logic                   resp_hit,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [VALUE_WIDTH-1:0] mem_wdata,
  input  logic                   mem_resp_valid,
  input  logic [VALUE_WIDTH-1:0] mem_rdata
);

  localparam int unsigned INDEX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W   = ADDR_WIDTH - INDEX_W;
  localparam int unsigned WAY_W   = $clog2(NUM_WAYS);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WB      = 3'd1;
  localparam logic [2:0] RF_REQ  = 3'd2;
  localparam logic [2:0] RF_WAIT = 3'd3;
  localparam logic [2:0] FILL    = 3'd4;

  logic [2:0] state, state_d;

  logic                   valid_q [NUM_SETS][NUM_WAYS];
  logic                   dirty_q [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]       age_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]       tag_q   [NUM_SETS][NUM_WAYS];
  logic [VALUE_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];

  logic                   lat_we;
  logic [ADDR_WIDTH-1:0]  lat_addr;
  logic [VALUE_WIDTH-1:0] lat_wdata;
  logic [WAY_W-1:0]       lat_way;
  logic [VALUE_WIDTH-1:0] rf_data;

  logic [INDEX_W-1:0]     req_idx, lat_idx, upd_set;
  logic [TAG_W-1:0]       req_tag, lat_tag;
  logic                   hit, vic_dirty, accept, hit_acc, upd_en;
  logic [WAY_W-1:0]       hit_way, vic_way, upd_way;
  logic [VALUE_WIDTH-1:0] fill_data;

  assign req_idx   = req_addr[INDEX_W-1:0];
  assign req_tag   = req_addr[ADDR_WIDTH-1:INDEX_W];
  assign lat_idx   = lat_addr[INDEX_W-1:0];
  assign lat_tag   = lat_addr[ADDR_WIDTH-1:INDEX_W];
  assign fill_data = lat_we ? lat_wdata : rf_data;

  // Tag lookup and victim choice: lowest invalid way wins over the oldest way.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_way = '0;
    for (int w = 0; w < int'(NUM_WAYS); w++) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (age_q[req_idx][w] == WAY_W'(NUM_WAYS - 1)) vic_way = WAY_W'(w);
    end
    for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) vic_way = WAY_W'(w);
    end
    vic_dirty = valid_q[req_idx][vic_way] && dirty_q[req_idx][vic_way];
  end

  always_comb begin
    state_d = state;
    accept  = (state == IDLE) && req_valid;
    hit_acc = accept && hit;
    upd_en  = hit_acc || (state == FILL);
    upd_set = (state == FILL) ? lat_idx : req_idx;
    upd_way = (state == FILL) ? lat_way : hit_way;
    case (state)
      IDLE: begin
        if (req_valid && !hit) begin
          if (vic_dirty)    state_d = WB;
          else if (!req_we) state_d = RF_REQ;
          else              state_d = FILL;
        end
      end
      WB:      if (mem_req_ready)  state_d = lat_we ? FILL : RF_REQ;
      RF_REQ:  if (mem_req_ready)  state_d = RF_WAIT;
      RF_WAIT: if (mem_resp_valid) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, registered outputs and the latched miss context.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_rdata    <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      lat_we        <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      lat_way       <= '0;
      rf_data       <= '0;
    end else begin
      state         <= state_d;
      req_ready     <= (state_d == IDLE);
      resp_valid    <= hit_acc || (state == FILL);
      resp_hit      <= hit_acc;
      mem_req_valid <= (state_d == WB) || (state_d == RF_REQ);
      mem_we        <= (state_d == WB);
      if (hit_acc)            resp_rdata <= req_we ? req_wdata : data_q[req_idx][hit_way];
      else if (state == FILL) resp_rdata <= fill_data;
      if (accept && state_d == WB) begin
        mem_addr  <= {tag_q[req_idx][vic_way], req_idx};
        mem_wdata <= data_q[req_idx][vic_way];
      end else if (state_d == RF_REQ && state != RF_REQ) begin
        mem_addr  <= (state == IDLE) ? req_addr : lat_addr;
      end
      if (accept && !hit) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_way   <= vic_way;
      end
      if (state == RF_WAIT && mem_resp_valid) rf_data <= mem_rdata;
    end
  end

  // Valid/dirty bits and LRU ages; the accessed way becomes youngest.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(NUM_SETS); s++) begin
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      if (hit_acc && req_we) dirty_q[req_idx][hit_way] <= 1'b1;
      if (state == FILL) begin
        valid_q[lat_idx][lat_way] <= 1'b1;
        dirty_q[lat_idx][lat_way] <= lat_we;
      end
      if (upd_en) begin
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
          if (WAY_W'(w) == upd_way)
            age_q[upd_set][w] <= '0;
          else if (age_q[upd_set][w] < age_q[upd_set][upd_way])
            age_q[upd_set][w] <= age_q[upd_set][w] + WAY_W'(1);
        end
      end
    end
  end

  // Line payload; meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (hit_acc && req_we) data_q[req_idx][hit_way] <= req_wdata;
    if (state == FILL) begin
      data_q[lat_idx][lat_way] <= fill_data;
      tag_q[lat_idx][lat_way]  <= lat_tag;
    end
  end

endmodule

// File: tb/tb_set_assoc_lru_cache.sv
// Bench for set_assoc_lru_cache: directed miss/hit scenarios plus a random stream,
// scored against a recency-list reference model and a behavioural next-level memory.
module tb_set_assoc_lru_cache;

  localparam int unsigned NUM_SETS = 4;
  localparam int unsigned NUM_WAYS = 2;
  localparam int unsigned TAG_W    = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic        req_ready;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_hit;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_we;
  logic        mem_req_ready = 1'b1;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  set_assoc_lru_cache #(.NUM_SETS(4), .NUM_WAYS(2), .ADDR_WIDTH(8), .VALUE_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [TAG_W-1:0] tag; logic [31:0] data; bit dirty; } line_t;
  typedef struct { bit hit; logic [31:0] rdata; bit chk_data; int lat; int drv_cyc; } exp_t;
  typedef struct { logic [7:0] addr; logic [31:0] data; } wb_t;

  line_t       ref_sets [NUM_SETS][$];   // most recently used first
  logic [31:0] ref_mem  [256];
  logic [31:0] dmem     [256];
  exp_t        sb [$];
  wb_t         wb_q [$];
  int          resp_log [$];

  int cyc = 0;
  int n_checks = 0, n_pass = 0;
  bit mode_rand = 0, stray_en = 0;
  int fixed_delay = 0, wb_stall = 0;
  int wb_stalled = 0, rd_cnt = 0, rd_count = 0;
  bit rd_pend = 0;
  logic [7:0] rd_addr = '0;
  exp_t mon_e;
  wb_t  rsp_w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic abort(input string name);
    check(name, 1'b0, 32'(cyc), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  // Reference model: each set is a recency list; a full set evicts its tail.
  task automatic model_access(input bit we, input logic [7:0] addr, input logic [31:0] wdata, input int drv);
    int s, pos;
    logic [TAG_W-1:0] t;
    line_t ln;
    exp_t e;
    wb_t w;
    bit wb;
    s = int'(addr[1:0]);
    t = addr[7:2];
    pos = -1;
    wb = 0;
    for (int i = 0; i < ref_sets[s].size(); i++) if (ref_sets[s][i].tag == t) pos = i;
    if (pos >= 0) begin
      ln = ref_sets[s][pos];
      ref_sets[s].delete(pos);
      if (we) begin ln.data = wdata; ln.dirty = 1; end
      e.hit = 1; e.chk_data = !we;
    end else begin
      if (ref_sets[s].size() == int'(NUM_WAYS)) begin
        ln = ref_sets[s].pop_back();
        if (ln.dirty) begin
          wb = 1;
          w.addr = {ln.tag, addr[1:0]};
          w.data = ln.data;
          ref_mem[w.addr] = ln.data;
          wb_q.push_back(w);
        end
      end
      ln.tag = t; ln.dirty = we;
      ln.data = we ? wdata : ref_mem[addr];
      e.hit = 0; e.chk_data = 1;
    end
    ref_sets[s].push_front(ln);
    e.rdata = ln.data;
    e.drv_cyc = drv;
    if (!mode_rand && fixed_delay == 0)
      e.lat = e.hit ? 1 : ((we ? 2 : 4) + (wb ? 1 + wb_stall : 0));
    else
      e.lat = 0;
    sb.push_back(e);
  endtask

  task automatic issue(input bit we, input logic [7:0] addr, input logic [31:0] wdata);
    int n = 0;
    @(negedge clk);
    while (!req_ready) begin
      req_valid = 1'b0;
      if (++n > 300) abort("issue_timeout");
      @(negedge clk);
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    model_access(we, addr, wdata, cyc);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (sb.size() != 0 || !req_ready) begin
      @(negedge clk);
      if (++n > 500) abort("drain_timeout");
    end
  endtask

  // Monitor: every response pops one expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      resp_log.push_back(cyc);
      if (sb.size() == 0) begin
        check("resp_unexpected", 1'b0, resp_rdata, 32'(0));
      end else begin
        mon_e = sb.pop_front();
        check("resp_hit", resp_hit == mon_e.hit, 32'(resp_hit), 32'(mon_e.hit));
        if (mon_e.chk_data) check("resp_rdata", resp_rdata == mon_e.rdata, resp_rdata, mon_e.rdata);
        if (mon_e.lat > 0)
          check("resp_latency", (cyc - mon_e.drv_cyc) == mon_e.lat, 32'(cyc - mon_e.drv_cyc), 32'(mon_e.lat));
      end
    end
  end

  // Next-level memory: handshakes, refill delay, write-back checking.
  always @(negedge clk) begin
    logic rdy;
    if (rst) begin
      rd_pend = 0; wb_stalled = 0;
      mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    end else begin
      mem_resp_valid = 1'b0;
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          mem_resp_valid = 1'b1; mem_rdata = dmem[rd_addr]; rd_pend = 0;
        end else rd_cnt--;
      end
      if (stray_en && mem_req_valid && mem_we && wb_stalled == 1) begin
        mem_resp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      end
      rdy = mode_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (mem_req_valid && mem_we && wb_stalled < wb_stall) begin
        rdy = 1'b0; wb_stalled++;
      end
      mem_req_ready = rdy;
      if (mem_req_valid && rdy) begin
        wb_stalled = 0;
        if (mem_we) begin
          if (wb_q.size() == 0) begin
            check("wb_unexpected", 1'b0, 32'(mem_addr), 32'(0));
          end else begin
            rsp_w = wb_q.pop_front();
            check("wb_addr", mem_addr == rsp_w.addr, 32'(mem_addr), 32'(rsp_w.addr));
            check("wb_data", mem_wdata == rsp_w.data, mem_wdata, rsp_w.data);
          end
          dmem[mem_addr] = mem_wdata;
        end else begin
          rd_pend = 1; rd_addr = mem_addr; rd_count++;
          rd_cnt = mode_rand ? int'($urandom_range(0, 3)) : fixed_delay;
        end
      end
    end
  end

  initial begin
    int rdc, seen, n;
    logic [7:0] a0;
    logic [31:0] d0, v;
    bit [NUM_WAYS-1:0] perm;
    logic [5:0] rt;
    logic [1:0] ri;

    for (int a = 0; a < 256; a++) begin
      v = $urandom;
      dmem[a] = v; ref_mem[a] = v;
    end
    dmem[8'h05] = 32'hAA; ref_mem[8'h05] = 32'hAA;

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready == 1'b1, 32'(req_ready), 32'(1));
    check("rst_resp_valid", resp_valid == 1'b0, 32'(resp_valid), 32'(0));
    check("rst_resp_hit", resp_hit == 1'b0, 32'(resp_hit), 32'(0));
    check("rst_resp_rdata", resp_rdata == 32'h0, resp_rdata, 32'(0));
    check("rst_mem_req_valid", mem_req_valid == 1'b0, 32'(mem_req_valid), 32'(0));
    check("rst_mem_we", mem_we == 1'b0, 32'(mem_we), 32'(0));
    check("rst_mem_addr", mem_addr == 8'h0, 32'(mem_addr), 32'(0));
    check("rst_mem_wdata", mem_wdata == 32'h0, mem_wdata, 32'(0));
    rst = 1'b0;

    // T1: clean read miss then hit
    issue(0, 8'h05, 0); drain();
    issue(0, 8'h05, 0); drain();

    // T2: write-allocate, then dirty eviction by a write with no refill
    rdc = rd_count;
    issue(1, 8'h01, 32'h11);
    issue(1, 8'h05, 32'h55);
    issue(0, 8'h01, 0);
    issue(1, 8'h09, 32'h99);
    drain();
    check("t2_no_refill", rd_count == rdc, 32'(rd_count), 32'(rdc));

    // T3: dirty read miss with a stalled write-back and a stray refill pulse
    wb_stall = 3; stray_en = 1;
    issue(0, 8'h0D, 0);
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0; a0 = '0; d0 = '0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid && mem_we) begin
        if (seen == 0) begin a0 = mem_addr; d0 = mem_wdata; end
        else begin
          check("t3_addr_stable", mem_addr == a0, 32'(mem_addr), 32'(a0));
          check("t3_wdata_stable", mem_wdata == d0, mem_wdata, d0);
        end
        check("t3_req_ready_busy", req_ready == 1'b0, 32'(req_ready), 32'(0));
        seen++;
      end
      @(negedge clk);
    end
    check("t3_wb_cycles", seen == 4, 32'(seen), 32'(4));
    drain();
    wb_stall = 0; stray_en = 0;

    // T4: back-to-back hits give one response per cycle
    issue(0, 8'h01, 0);
    issue(0, 8'h05, 0);
    drain();
    resp_log.delete();
    issue(0, 8'h01, 0);
    issue(0, 8'h05, 0);
    issue(0, 8'h01, 0);
    drain();
    check("t4_resp_count", resp_log.size() == 3, 32'(resp_log.size()), 32'(3));
    if (resp_log.size() == 3) begin
      check("t4_consecutive_0", resp_log[1] - resp_log[0] == 1, 32'(resp_log[1] - resp_log[0]), 32'(1));
      check("t4_consecutive_1", resp_log[2] - resp_log[1] == 1, 32'(resp_log[2] - resp_log[1]), 32'(1));
    end

    // T5: reset while waiting for refill data
    fixed_delay = 8;
    issue(0, 8'h33, 0);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_req_valid) begin @(negedge clk); if (++n > 50) abort("t5_wait_req"); end
    while (mem_req_valid)  begin @(negedge clk); if (++n > 50) abort("t5_wait_rfwait"); end
    rst = 1'b1;
    @(negedge clk);
    check("t5_mem_req_valid", mem_req_valid == 1'b0, 32'(mem_req_valid), 32'(0));
    check("t5_req_ready", req_ready == 1'b1, 32'(req_ready), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    sb.delete(); wb_q.delete();
    for (int s = 0; s < int'(NUM_SETS); s++) ref_sets[s].delete();
    fixed_delay = 0;
    issue(0, 8'h33, 0);
    drain();

    // T6: random stream with a stalling, variable-latency memory
    mode_rand = 1;
    for (int i = 0; i < 1000; i++) begin
      rt = 6'($urandom_range(0, 5));
      ri = 2'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 1)), {rt, ri}, $urandom);
    end
    drain();
    for (int s = 0; s < int'(NUM_SETS); s++) begin
      perm = '0;
      for (int w = 0; w < int'(NUM_WAYS); w++) perm[dut.age_q[s][w]] = 1'b1;
      check("lru_permutation", perm == '1, 32'(perm), 32'((1 << NUM_WAYS) - 1));
    end
    check("wb_pending", wb_q.size() == 0, 32'(wb_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
